// File: rtl/nidna_axil_slave.sv
// AXI4-Lite responder for NIDNAPort: four R/W user registers plus a
// DNA_PORT read engine exposing the device ID read-only.
module nidna_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int DNA_BITS           = 57,
    parameter int DNA_CLK_DIV        = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            dna_clk,
    output logic                            dna_read,
    output logic                            dna_shift,
    input  logic                            dna_dout
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_e;

    localparam int HALF = DNA_CLK_DIV / 2;
    localparam int CW   = (DNA_CLK_DIV > 2) ? $clog2(DNA_CLK_DIV) : 1;
    localparam int BW   = $clog2(DNA_BITS + 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic [DNA_BITS-1:0]   shreg_q, shreg_d;
    logic [63:0]           dna_q, dna_d;
    logic                  dclk_q, dclk_d;
    logic                  read_q, read_d;
    logic                  shift_q, shift_d;
    logic                  done_q, done_d;
    logic                  boot_q, boot_d;
    logic [31:0]           regs_q [4];
    logic [31:0]           regs_d [4];
    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_word;

    logic       wr_hs, rd_hs, busy, restart, tick, rise, fall, start;
    logic [2:0] wr_idx, rd_idx;
    logic       unused_addr;

    assign unused_addr = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign wr_idx  = s00_axi_awaddr[4:2];
    assign rd_idx  = s00_axi_araddr[4:2];
    assign wr_hs   = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_hs   = arready_q & s00_axi_arvalid;
    assign busy    = (state_q == S_LOAD) || (state_q == S_SHIFT);
    assign restart = wr_hs && (wr_idx == 3'd6) && s00_axi_wstrb[0]
                     && s00_axi_wdata[0];
    assign tick    = busy && (cnt_q == CW'(HALF - 1));
    assign rise    = tick & ~dclk_q;
    assign fall    = tick & dclk_q;
    assign start   = ((state_q == S_IDLE) && (boot_q || restart))
                     || ((state_q == S_DONE) && restart);

    always_comb begin
        rd_word = '0;
        case (rd_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_word = regs_q[rd_idx[1:0]];
            3'd4:    rd_word = dna_q[31:0];
            3'd5:    rd_word = dna_q[63:32];
            3'd6:    rd_word = {30'd0, busy, done_q};
            default: rd_word = '0;
        endcase
    end

    always_comb begin
        awready_d = s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = wr_hs | (bvalid_q & ~s00_axi_bready);
        arready_d = s00_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rd_hs | (rvalid_q & ~s00_axi_rready);
        rdata_d   = rd_hs ? rd_word : rdata_q;
        regs_d    = regs_q;
        if (wr_hs && !wr_idx[2]) begin
            for (int b = 0; b < 4; b++) begin
                if (s00_axi_wstrb[b]) begin
                    regs_d[wr_idx[1:0]][8*b +: 8] = s00_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dclk_d  = dclk_q;
        read_d  = read_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        dna_d   = dna_q;
        done_d  = done_q;
        boot_d  = 1'b0;
        if (busy) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) dclk_d = ~dclk_q;
        end
        unique case (state_q)
            S_LOAD: begin
                if (fall) begin
                    state_d = S_SHIFT;
                    read_d  = 1'b0;
                    shift_d = 1'b1;
                end
            end
            S_SHIFT: begin
                // DOUT already shows the MSB after the load edge
                if (rise) begin
                    shreg_d = {shreg_q[DNA_BITS-2:0], dna_dout};
                    bits_d  = bits_q + 1'b1;
                end
                if (fall && (bits_q == BW'(DNA_BITS))) begin
                    state_d = S_DONE;
                    shift_d = 1'b0;
                    dna_d   = 64'(shreg_q);
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase
        if (start) begin
            state_d = S_LOAD;
            read_d  = 1'b1;
            cnt_d   = '0;
            dclk_d  = 1'b0;
            bits_d  = '0;
            shreg_d = '0;
            dna_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dclk_q    <= 1'b0;
            read_q    <= 1'b0;
            shift_q   <= 1'b0;
            bits_q    <= '0;
            shreg_q   <= '0;
            dna_q     <= '0;
            done_q    <= 1'b0;
            boot_q    <= 1'b1;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dclk_q    <= dclk_d;
            read_q    <= read_d;
            shift_q   <= shift_d;
            bits_q    <= bits_d;
            shreg_q   <= shreg_d;
            dna_q     <= dna_d;
            done_q    <= done_d;
            boot_q    <= boot_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign dna_clk         = dclk_q;
    assign dna_read        = read_q;
    assign dna_shift       = shift_q;

endmodule

// File: tb/tb_nidna_axil_slave.sv
// Bench for nidna_axil_slave: AXI-Lite register access, DNA_PORT model,
// backpressure, restart handling and asynchronous reset.
module tb_nidna_axil_slave;

    localparam int DNA_BITS = 57;
    localparam int DIV      = 4;
    localparam int BOUND    = (DNA_BITS + 2) * DIV + 8;
    localparam logic [56:0] DNA_VAL = 57'h123456789ABCDEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic        dna_clk, dna_read, dna_shift, dna_dout;

    int cyc = 0;
    int nshift = 0;
    int n_chk = 0;
    int n_fail = 0;
    logic [56:0] sr = '0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dna_dout = sr[56];
    always @(posedge dna_clk) begin
        if (dna_read) begin
            sr <= DNA_VAL;
        end else if (dna_shift) begin
            sr <= {sr[55:0], 1'b0};
            nshift <= nshift + 1;
        end
    end

    nidna_axil_slave dut (
        .s00_axi_aclk(clk),       .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),  .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),.s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),    .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),  .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),  .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),  .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),.s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),    .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),  .dna_clk(dna_clk),
        .dna_read(dna_read),      .dna_shift(dna_shift),
        .dna_dout(dna_dout)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [63:0] outs();
        return {20'd0, awready, wready, bvalid, bresp, arready, rvalid,
                rresp, rdata, dna_clk, dna_read, dna_shift};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input string nm);
        int t;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!(awready && wready) && t < 20);
        chk({nm, "_accept"}, {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk({nm, "_bresp"}, {bvalid, bresp}, 3'b100);
    endtask

    task automatic ar_handshake(input logic [4:0] a);
        int t;
        araddr = a; arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 20);
        chk("ar_accept", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic collect(input string nm);
        int t;
        logic [31:0] e;
        t = 0;
        while (!(rvalid && rready) && t < 20) begin @(negedge clk); t++; end
        chk({nm, "_rvalid"}, rvalid, 1);
        if (rvalid) begin
            e = sb.pop_front();
            chk(nm, {rresp, rdata}, {2'b00, e});
        end
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] e,
                            input string nm);
        sb.push_back(e);
        ar_handshake(a);
        collect(nm);
    endtask

    task automatic read_raw(input logic [4:0] a, output logic [31:0] d);
        int t;
        ar_handshake(a);
        t = 0;
        while (!rvalid && t < 20) begin @(negedge clk); t++; end
        chk("raw_rvalid", rvalid, 1);
        d = rdata;
    endtask

    task automatic poll_done(input string nm, input int t0);
        logic [31:0] d;
        d = '0;
        while (d != 32'h1 && (cyc - t0) < BOUND) read_raw(5'h18, d);
        chk(nm, d, 32'h1);
    endtask

    initial begin
        logic [31:0] d;
        int t_rel, base, t;

        tbl[0]  = '{1'b1, 5'h00, 32'h1,        4'hF, 32'h0};
        tbl[1]  = '{1'b1, 5'h04, 32'h2,        4'hF, 32'h0};
        tbl[2]  = '{1'b1, 5'h08, 32'h3,        4'hF, 32'h0};
        tbl[3]  = '{1'b1, 5'h0C, 32'h4,        4'hF, 32'h0};
        tbl[4]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h1};
        tbl[5]  = '{1'b0, 5'h04, 32'h0,        4'h0, 32'h2};
        tbl[6]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h3};
        tbl[7]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h4};
        tbl[8]  = '{1'b1, 5'h00, 32'hAABBCCDD, 4'h1, 32'h0};
        tbl[9]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h000000DD};
        tbl[10] = '{1'b1, 5'h04, 32'hAABBCCDD, 4'hA, 32'h0};
        tbl[11] = '{1'b0, 5'h04, 32'h0,        4'h0, 32'hAA00CC02};
        tbl[12] = '{1'b0, 5'h1C, 32'h0,        4'h0, 32'h0};

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        t_rel = cyc;
        @(negedge clk);
        chk("auto_start", {dna_read, dna_shift, dna_clk}, 3'b100);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, "tbl_wr");
            else           axi_read(tbl[i].addr, tbl[i].exp, "tbl_rd");
        end

        read_raw(5'h18, d);
        chk("status_busy", d, 32'h2);
        axi_write(5'h18, 32'h1, 4'hF, "restart_busy");
        poll_done("dna_done", t_rel);
        axi_read(5'h10, 32'h89ABCDEF, "dna_lo");
        axi_read(5'h14, 32'h01234567, "dna_hi");
        axi_write(5'h10, 32'hFFFFFFFF, 4'hF, "ro_write");
        axi_read(5'h10, 32'h89ABCDEF, "dna_lo_ro");

        repeat (2) @(negedge clk);
        awaddr = 5'h04; wdata = 32'h11112222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h08; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0;
        sb.push_back(32'h3);
        t = 0;
        do begin @(negedge clk); t++; end while (!(awready && arready) && t < 20);
        chk("bp_accept", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        wdata = 32'hDEADBEEF; araddr = 5'h00;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", {bvalid, rvalid, awready, arready, rdata},
                {4'b1100, 32'h3});
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        collect("bp_read");
        @(negedge clk);
        axi_read(5'h04, 32'h11112222, "bp_write_kept");

        repeat (2) @(negedge clk);
        awaddr = 5'h08; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h08; arvalid = 1'b1;
        sb.push_back(32'h3);
        t = 0;
        do begin @(negedge clk); t++; end while (!(awready && arready) && t < 20);
        chk("rw_accept", {awready, arready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("rw_bresp", {bvalid, bresp}, 3'b100);
        collect("rw_same_old");
        axi_read(5'h08, 32'h55, "rw_same_new");

        base = nshift;
        axi_write(5'h18, 32'h1, 4'hF, "restart_idle");
        read_raw(5'h18, d);
        chk("status_restart", d, 32'h2);
        axi_read(5'h10, 32'h0, "dna_cleared");
        t = 0;
        while ((nshift - base) < 20 && t < 400) begin @(negedge clk); t++; end
        chk("mid_shift", dna_shift, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", outs(), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t_rel = cyc;
        poll_done("dna_done_rst", t_rel);
        axi_read(5'h10, 32'h89ABCDEF, "dna_lo_rst");
        axi_read(5'h14, 32'h01234567, "dna_hi_rst");
        axi_read(5'h00, 32'h0, "reg0_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
